time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Push-button time-setting controller for a watch counter. Four raw
//   buttons are synchronized and debounced. Their rising edges drive a
//   small IDLE/EDIT/COMMIT FSM that edits a shadow copy of the live time.
//   When the edit ends, the FSM emits a one-cycle load strobe.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   sw_in[3:0] raw buttons, pressed=1: [0] MODE [1] NEXT [2] UP [3] DOWN
//   year..second  live binary time from the watch counter (8b each)
//   set_time   one-cycle load strobe to the watch counter
//   bin_time   {year,month,day,hour,minute,second} shadow registers
//   edit_mode  high in EDIT and COMMIT
//   field_sel  field being edited: 0 yr,1 mon,2 day,3 hr,4 min,5 sec
// ---------------------------------------------------------------------------

// Per-button conditioning: 2-flop synchronizer, stability-window
// debouncer, and press (0->1) edge detector.
module time_set_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // The counter measures how long sync2 has disagreed with the
            // debounced level. Any bounce back to the old value restarts
            // the window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;
endmodule

module time_set_ctrl #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_in,
    input  logic [7:0]  year,
    input  logic [7:0]  month,
    input  logic [7:0]  day,
    input  logic [7:0]  hour,
    input  logic [7:0]  minute,
    input  logic [7:0]  second,
    output logic        set_time,
    output logic [47:0] bin_time,
    output logic        edit_mode,
    output logic [2:0]  field_sel
);
    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t     state, n_state;
    logic [3:0] ev;
    logic       ev_mode, ev_next, ev_up, ev_down;
    logic       adj_up, adj_dn;

    logic [7:0] yr, mo, dy, hr, mi, sc;
    logic [7:0] n_yr, n_mo, n_dy, n_hr, n_mi, n_sc;
    logic [2:0] n_fs;
    logic [7:0] dim;

    time_set_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [3:0] (
        .clk  (clk),
        .rst  (rst),
        .raw  (sw_in),
        .rise (ev)
    );

    assign ev_mode = ev[0];
    assign ev_next = ev[1];
    assign ev_up   = ev[2];
    assign ev_down = ev[3];
    // Simultaneous UP and DOWN cancel each other.
    assign adj_up  = ev_up & ~ev_down;
    assign adj_dn  = ev_down & ~ev_up;

    function automatic logic [7:0] days_in(input logic [7:0] m, input logic [7:0] y);
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: days_in = 8'd30;
            8'd2:                    days_in = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 days_in = 8'd31;
        endcase
    endfunction

    // Increment or decrement with wrap inside [lo,hi]. Out-of-range values
    // (e.g. a bad live value) land back inside the range.
    function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi, input logic up);
        if (up) step = (v >= hi) ? lo : v + 8'd1;
        else    step = (v <= lo) ? hi : v - 8'd1;
    endfunction

    assign dim = days_in(mo, yr);

    always_comb begin
        n_state = state;
        n_fs    = field_sel;
        n_yr    = yr;
        n_mo    = mo;
        n_dy    = dy;
        n_hr    = hr;
        n_mi    = mi;
        n_sc    = sc;
        case (state)
            IDLE: begin
                if (ev_mode) begin
                    n_state = EDIT;
                    n_fs    = 3'd0;
                    n_yr    = year;
                    n_mo    = month;
                    n_dy    = day;
                    n_hr    = hour;
                    n_mi    = minute;
                    n_sc    = second;
                end
            end
            EDIT: begin
                if (ev_mode) begin
                    n_state = COMMIT;
                end else if (ev_next) begin
                    n_fs = (field_sel == 3'd5) ? 3'd0 : field_sel + 3'd1;
                end else if (adj_up || adj_dn) begin
                    case (field_sel)
                        3'd0:    n_yr = step(yr, 8'd0, 8'd99, adj_up);
                        3'd1:    n_mo = step(mo, 8'd1, 8'd12, adj_up);
                        3'd2:    n_dy = step(dy, 8'd1, dim,   adj_up);
                        3'd3:    n_hr = step(hr, 8'd0, 8'd23, adj_up);
                        3'd4:    n_mi = step(mi, 8'd0, 8'd59, adj_up);
                        3'd5:    n_sc = step(sc, 8'd0, 8'd59, adj_up);
                        default: ;
                    endcase
                end
                // dim reflects the registered year/month, so a day that a
                // year/month change made illegal is trimmed one cycle
                // later. This trim also applies in the cycle that leaves
                // for COMMIT, so the committed value is always legal.
                if (n_dy == dy && dy > dim)
                    n_dy = dim;
            end
            COMMIT: begin
                n_state = IDLE;
            end
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            set_time  <= 1'b0;
            edit_mode <= 1'b0;
            field_sel <= 3'd0;
            yr        <= 8'd0;
            mo        <= 8'd1;
            dy        <= 8'd1;
            hr        <= 8'd0;
            mi        <= 8'd0;
            sc        <= 8'd0;
        end else begin
            state     <= n_state;
            // Outputs are registered from the next state, so the strobe
            // coincides with the COMMIT state itself.
            set_time  <= (n_state == COMMIT);
            edit_mode <= (n_state != IDLE);
            field_sel <= n_fs;
            yr        <= n_yr;
            mo        <= n_mo;
            dy        <= n_dy;
            hr        <= n_hr;
            mi        <= n_mi;
            sc        <= n_sc;
        end
    end

    assign bin_time = {yr, mo, dy, hr, mi, sc};
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl (DEB_CYCLES=4). Stimulus queues the
// expected output snapshot {set_time, edit_mode, field_sel, bin_time} for
// every output change it provokes. The monitor compares each change it
// sees against the next queued snapshot.
module tb_time_set_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_in;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        set_time, edit_mode;
    logic [47:0] bin_time;
    logic [2:0]  field_sel;

    always #5 clk = ~clk;

    time_set_ctrl #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .set_time  (set_time),
        .bin_time  (bin_time),
        .edit_mode (edit_mode),
        .field_sel (field_sel)
    );

    typedef logic [52:0] snap_t;
    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam logic [47:0] RST_T = 48'h00_01_01_00_00_00;
    localparam logic [47:0] LIVE2 = 48'h17_0C_0F_00_2D_3B;
    localparam logic [47:0] ED2   = 48'h17_01_0F_00_2D_3B;

    task automatic push(input logic st, input logic em, input logic [2:0] fs,
                        input logic [47:0] bt);
        exp_q.push_back({st, em, fs, bt});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        sw_in = m;
        cyc(hold);
        sw_in = 4'b0;
        cyc(12);
    endtask

    // Monitor: any change of the output vector is one DUT transaction.
    initial begin
        snap_t prev, cur, e;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = {set_time, edit_mode, field_sel, bin_time};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change got st=%b em=%b fs=%0d bt=%h want no change",
                             cur[52], cur[51], cur[50:48], cur[47:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL snapshot got st=%b em=%b fs=%0d bt=%h want st=%b em=%b fs=%0d bt=%h",
                                 cur[52], cur[51], cur[50:48], cur[47:0],
                                 e[52], e[51], e[50:48], e[47:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int k;
        rst = 1'b0; sw_in = 4'b0;
        year = 8'h18; month = 8'h02; day = 8'h1D;
        hour = 8'h0A; minute = 8'h14; second = 8'h1E;
        push(0, 0, 3'd0, RST_T);
        cyc(5); rst = 1'b1; cyc(3);

        // Short MODE glitch: no event, nothing changes.
        press(4'b0001, 3);
        // MODE: capture 24/02/29 10:20:30.
        push(0, 1, 3'd0, 48'h18_02_1D_0A_14_1E);
        press(4'b0001, 10);
        // UP on year -> 25, then day trimmed to 28 a cycle later.
        push(0, 1, 3'd0, 48'h19_02_1D_0A_14_1E);
        push(0, 1, 3'd0, 48'h19_02_1C_0A_14_1E);
        press(4'b0100, 10);
        // MODE -> one-cycle strobe, then back to IDLE.
        push(1, 1, 3'd0, 48'h19_02_1C_0A_14_1E);
        push(0, 0, 3'd0, 48'h19_02_1C_0A_14_1E);
        press(4'b0001, 10);

        // Second edit: 23/12/15 00:45:59.
        year = 8'h17; month = 8'h0C; day = 8'h0F;
        hour = 8'h00; minute = 8'h2D; second = 8'h3B;
        push(0, 1, 3'd0, LIVE2);  press(4'b0001, 10);
        push(0, 1, 3'd1, LIVE2);  press(4'b0010, 10);
        push(0, 1, 3'd1, ED2);    press(4'b0100, 10);   // month 12 -> 1
        push(0, 1, 3'd2, ED2);    press(4'b0010, 10);
        push(0, 1, 3'd3, ED2);    press(4'b0010, 10);
        push(0, 1, 3'd3, 48'h17_01_0F_17_2D_3B); press(4'b1000, 10); // hour 0 -> 23
        push(0, 1, 3'd3, ED2);    press(4'b0100, 10);   // hour 23 -> 0
        for (int i = 1; i <= 6; i++) begin
            k = (3 + i) % 6;
            push(0, 1, 3'(k), ED2);
            press(4'b0010, 10);
        end
        // UP and DOWN together: no change.
        press(4'b1100, 10);
        // MODE and UP together: commit wins, hour untouched.
        push(1, 1, 3'd3, ED2);
        push(0, 0, 3'd3, ED2);
        press(4'b0101, 10);

        // Reset in the middle of an edit abandons it.
        push(0, 1, 3'd0, LIVE2);                 press(4'b0001, 10);
        push(0, 1, 3'd0, 48'h18_0C_0F_00_2D_3B); press(4'b0100, 10);
        push(0, 0, 3'd0, RST_T);
        rst = 1'b0; cyc(4); rst = 1'b1; cyc(20);
        // Operation resumes from IDLE.
        push(0, 1, 3'd0, LIVE2);  press(4'b0001, 10);
        cyc(5);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expected got %0d outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
